msx_reload_seq: RTL and testbench
=================================

MSX_RELOAD_SEQ -- requirements
Module: msx_reload_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles `reload` must stay low before the sequence leaves HOLD.
REQ-002 SHALL have parameter TAIL_CYCLES, default 8, meaning the number of cycles `msx_reset` stays asserted after clearing completes.
REQ-003 SHALL have port `clk`, input, 1 bit: the single system clock.
REQ-004 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port `reload`, input, 1 bit: level request from the configuration stage; high while the active config differs from the latched config.
REQ-006 SHALL have port `sram_size`, input, 8 bits: selected cartridge SRAM size in kB (0 = none).
REQ-007 SHALL have port `msx_reset`, output, 1 bit: holds the MSX core in reset.
REQ-008 SHALL have port `busy`, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port `mem_wr`, output, 1 bit: SRAM clear write request.
REQ-010 SHALL have port `mem_addr`, output, 15 bits: byte address within the SRAM region.
REQ-011 SHALL have port `mem_data`, output, 8 bits: write data, constant 8'hFF.
REQ-012 SHALL have port `mem_ack`, input, 1 bit: one-cycle write acknowledge from the SDRAM arbiter.

Function
REQ-013 SHALL implement the state machine IDLE, HOLD, CLEAR, TAIL; the encoding SHALL be a package enum.
REQ-014 From IDLE, `reload`=1 SHALL enter HOLD on the next edge, so `msx_reset` goes high 1 cycle after `reload` rises.
REQ-015 In HOLD, the hold counter SHALL reload to 0 on every cycle with `reload`=1, and increment otherwise.
REQ-016 HOLD SHALL exit when the counter reaches HOLD_CYCLES-1 with `reload`=0.
REQ-017 On HOLD exit, `sram_size` SHALL be sampled; the byte count SHALL be min(sram_size, 32)*1024.
REQ-018 On HOLD exit, the state SHALL go to CLEAR if that count is nonzero, else to TAIL.
REQ-019 In CLEAR, `mem_wr` SHALL stay high with `mem_addr` stable until `mem_ack`=1.
REQ-020 On `mem_ack`, `mem_addr` SHALL increment by 1; after the ack for address count-1, the state SHALL go to TAIL and `mem_wr` SHALL drop in that same cycle.
REQ-021 `mem_addr` arithmetic SHALL be 15-bit; size 32 SHALL end at 15'h7FFF with no wrap or extra write.
REQ-022 `mem_ack` received outside CLEAR SHALL be ignored.
REQ-023 `reload`=1 during CLEAR or TAIL SHALL abort to HOLD with the counter cleared, `mem_wr` dropped, and `mem_addr` reset to 0; a later HOLD exit restarts the clear from address 0.
REQ-024 TAIL SHALL count TAIL_CYCLES cycles and then go to IDLE; `msx_reset` SHALL be high in HOLD, CLEAR and TAIL, and low only in IDLE.
REQ-025 If `reload` and `mem_ack` occur in the same cycle, the abort SHALL win and the address SHALL not advance.
REQ-026 All outputs SHALL be registered; `mem_data` SHALL be constant 8'hFF.

Reset
REQ-027 Asserting `reset_n`=0 SHALL asynchronously force: state HOLD, counters 0, `msx_reset`=1, `busy`=1, `mem_wr`=0, `mem_addr`=0.
REQ-028 After `reset_n` release, the block SHALL run a full HOLD→CLEAR/TAIL→IDLE power-up sequence using the then-current `sram_size`.
REQ-029 Reset asserted mid-CLEAR SHALL drop `mem_wr` immediately (asynchronously) and discard clear progress.

Structure
REQ-030 The state enum and the constants SRAM_MAX_KB=32 and SRAM_FILL=8'hFF SHALL live in the MSX package.
REQ-031 The block SHALL be a single module; the HOLD/TAIL counter SHALL be a shared internal counter and SHALL NOT be a sub-module.

Verification
REQ-032 Power-up: `reset_n` low then high, `reload`=0, `sram_size`=0 → `msx_reset` high for 16+8 cycles, then IDLE, with no `mem_wr`.
REQ-033 Clear 1 kB: `reload` pulsed 3 cycles, `sram_size`=1, ack 1 cycle after each request → 1024 writes to addresses 0..1023 with data FF, then 8 TAIL cycles, then `msx_reset`=0.
REQ-034 Clamp: `sram_size`=8'd64 → exactly 32768 writes with last address 15'h7FFF and no wrap to 0.
REQ-035 Abort: `reload` raised after 100 acks in CLEAR → `mem_wr`=0 next cycle; after `reload` drops, the clear restarts at address 0 and completes all writes.
REQ-036 Simultaneous events: `reload` and `mem_ack` in the same cycle → state HOLD with no address increment; a stray `mem_ack` in IDLE → no state change.
REQ-037 Async reset mid-CLEAR → `mem_wr`=0 and `msx_reset`=1 with no clock edge required.

Source files
------------

// File: rtl/msx_reload_seq_pkg.sv
// Shared types and constants for the MSX reload/reset sequencer.
package msx_reload_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  localparam int         SRAM_MAX_KB = 32;
  localparam logic [7:0] SRAM_FILL   = 8'hFF;
  localparam int         ADDR_W      = 15;

  // Last byte address to clear for a given SRAM size in kB, clamped to
  // SRAM_MAX_KB. Only meaningful for a nonzero size.
  function automatic logic [ADDR_W-1:0] clear_last_addr(input logic [7:0] size_kb);
    logic [5:0] kb;
    kb = (size_kb > 8'(SRAM_MAX_KB)) ? 6'(SRAM_MAX_KB) : size_kb[5:0];
    return ADDR_W'({kb, 10'd0} - 16'd1);
  endfunction

endpackage

// File: rtl/msx_reload_seq_if.sv
// SRAM clear write channel between the sequencer and the SDRAM arbiter.
interface msx_reload_seq_if;
  import msx_reload_seq_pkg::*;

  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;

  modport master (output mem_wr, output mem_addr, output mem_data, input mem_ack);
  modport slave  (input mem_wr, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/msx_reload_seq.sv
// Holds the MSX core in reset while the configuration settles, clears the
// cartridge SRAM region to FF, then keeps reset asserted for a short tail.
module msx_reload_seq
  import msx_reload_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int TAIL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reload,
  input  logic [7:0] sram_size,
  output logic       msx_reset,
  output logic       busy,
  msx_reload_seq_if.master mem
);

  // One counter serves both HOLD and TAIL, so it is sized for the larger.
  localparam int CNT_MAX = (HOLD_CYCLES > TAIL_CYCLES) ? HOLD_CYCLES : TAIL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_CYCLES - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [ADDR_W-1:0] last_addr, last_nx;
  logic              wr_q, wr_nx;
  logic              rst_q, rst_nx;
  logic              busy_q, busy_nx;
  logic              hold_done;

  assign hold_done = !reload && (cnt == HOLD_LAST);

  // State, counter and registered outputs; reset lands in HOLD for power-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      addr   <= '0;
      wr_q   <= 1'b0;
      rst_q  <= 1'b1;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr   <= addr_nx;
      wr_q   <= wr_nx;
      rst_q  <= rst_nx;
      busy_q <= busy_nx;
    end
  end

  // Clear end address is data only, captured when HOLD exits.
  always_ff @(posedge clk) begin
    last_addr <= last_nx;
  end

  // Next-state decision; reload always wins over a same-cycle ack.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (reload) state_nx = ST_HOLD;
      ST_HOLD:  if (hold_done) state_nx = (sram_size != 8'd0) ? ST_CLEAR : ST_TAIL;
      ST_CLEAR: begin
        if (reload)                                state_nx = ST_HOLD;
        else if (mem.mem_ack && addr == last_addr) state_nx = ST_TAIL;
      end
      ST_TAIL: begin
        if (reload)                state_nx = ST_HOLD;
        else if (cnt == TAIL_LAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_HOLD;
    endcase
  end

  // Counter, address and output values for the next cycle.
  always_comb begin
    cnt_nx  = cnt;
    addr_nx = addr;
    last_nx = last_addr;

    // Counter restarts on any state change or reload, runs in HOLD/TAIL.
    if (state_nx != state || reload)
      cnt_nx = '0;
    else if (state == ST_HOLD || state == ST_TAIL)
      cnt_nx = cnt + 1'b1;

    // Address parks at the final address after the last ack, never wraps.
    if (state_nx == ST_HOLD)
      addr_nx = '0;
    else if (state == ST_CLEAR && state_nx == ST_CLEAR && mem.mem_ack)
      addr_nx = addr + 1'b1;

    if (state == ST_HOLD && hold_done)
      last_nx = clear_last_addr(sram_size);

    wr_nx   = (state_nx == ST_CLEAR);
    rst_nx  = (state_nx != ST_IDLE);
    busy_nx = (state_nx != ST_IDLE);
  end

  assign msx_reset    = rst_q;
  assign busy         = busy_q;
  assign mem.mem_wr   = wr_q;
  assign mem.mem_addr = addr;
  assign mem.mem_data = SRAM_FILL;

endmodule

// File: tb/tb_msx_reload_seq.sv
// Directed testbench for msx_reload_seq with a simple ack-generating arbiter.
module tb_msx_reload_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reload;
  logic [7:0] sram_size;
  logic       msx_reset;
  logic       busy;

  msx_reload_seq_if mem_bus ();

  msx_reload_seq #(.HOLD_CYCLES(16), .TAIL_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reload    (reload),
    .sram_size (sram_size),
    .msx_reset (msx_reset),
    .busy      (busy),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // Arbiter model: acks write requests (every cycle when fast, else one
  // cycle after the request), records them, returns when busy drops, after
  // stop_after writes, or on timeout.
  task automatic serve(input bit fast, input int stop_after, input int limit,
                       output int nwr, output int nerr, output logic [14:0] last_a,
                       output int last_cyc, output int end_cyc, output bit timeout);
    int w;
    bit done;
    nwr = 0; nerr = 0; last_a = '0; last_cyc = 0; end_cyc = 0; timeout = 0;
    w = 0; done = 0;
    mem_bus.mem_ack = 1'b0;
    for (int cyc = 1; cyc <= limit && !done; cyc++) begin
      @(negedge clk);
      if (mem_bus.mem_wr && (fast || (!mem_bus.mem_ack && w == 1))) begin
        if (mem_bus.mem_addr !== 15'(nwr) || mem_bus.mem_data !== 8'hFF) nerr++;
        last_a   = mem_bus.mem_addr;
        last_cyc = cyc;
        nwr++;
        mem_bus.mem_ack = 1'b1;
        w = 0;
        if (nwr == stop_after) done = 1;
      end else begin
        mem_bus.mem_ack = 1'b0;
        if (mem_bus.mem_wr) w++; else w = 0;
        if (!busy) begin
          end_cyc = cyc;
          done    = 1;
        end
      end
      if (!done && cyc == limit) timeout = 1;
    end
  endtask

  task automatic pulse_reload(input int cycles);
    @(negedge clk);
    reload = 1'b1;
    repeat (cycles) @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reload = 1'b0; sram_size = 8'd0; mem_bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (msx_reset !== 1'b1 || busy !== 1'b1 || mem_bus.mem_wr !== 1'b0 ||
        mem_bus.mem_addr !== 15'd0 || mem_bus.mem_data !== 8'hFF) begin
      miss++;
      $display("FAIL reset_state: rst=%b busy=%b wr=%b addr=%h data=%h, want 1 1 0 0000 ff",
               msx_reset, busy, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_data);
    end
  endtask

  task automatic test_powerup();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd0;
    reset_n = 1'b1;
    serve(1'b1, 0, 100, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || ec !== 24) begin
      miss++;
      $display("FAIL powerup_len: timeout=%0b edges=%0d, want 0 24", to, ec);
    end
    vec++;
    if (nwr !== 0) begin
      miss++;
      $display("FAIL powerup_nowr: writes=%0d, want 0", nwr);
    end
  endtask

  task automatic test_clear_1k();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd1;
    @(negedge clk);
    reload = 1'b1;
    vec++;
    if (msx_reset !== 1'b0) begin
      miss++;
      $display("FAIL idle_rst: got %b want 0", msx_reset);
    end
    @(negedge clk);
    vec++;
    if (msx_reset !== 1'b1) begin
      miss++;
      $display("FAIL rst_latency: got %b want 1", msx_reset);
    end
    repeat (2) @(negedge clk);
    reload = 1'b0;
    serve(1'b0, 0, 6000, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || nwr !== 1024 || nerr !== 0 || la !== 15'd1023) begin
      miss++;
      $display("FAIL clear_1k: timeout=%0b writes=%0d errs=%0d last=%h, want 0 1024 0 03ff",
               to, nwr, nerr, la);
    end
    // ack edge plus 8 TAIL cycles before busy is seen low
    vec++;
    if (ec - lc !== 9) begin
      miss++;
      $display("FAIL tail_len: got %0d want 9", ec - lc);
    end
    vec++;
    if (msx_reset !== 1'b0) begin
      miss++;
      $display("FAIL clear_1k_end: rst=%b want 0", msx_reset);
    end
  endtask

  task automatic test_clamp();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd64;
    pulse_reload(1);
    serve(1'b1, 0, 34000, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || nwr !== 32768 || nerr !== 0 || la !== 15'h7FFF) begin
      miss++;
      $display("FAIL clamp: timeout=%0b writes=%0d errs=%0d last=%h, want 0 32768 0 7fff",
               to, nwr, nerr, la);
    end
    vec++;
    if (mem_bus.mem_addr !== 15'h7FFF || mem_bus.mem_wr !== 1'b0) begin
      miss++;
      $display("FAIL clamp_nowrap: addr=%h wr=%b want 7fff 0", mem_bus.mem_addr, mem_bus.mem_wr);
    end
  endtask

  task automatic test_abort();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd1;
    pulse_reload(1);
    serve(1'b1, 100, 2000, nwr, nerr, la, lc, ec, to);
    @(negedge clk);
    vec++;
    if (nwr !== 100 || nerr !== 0 || mem_bus.mem_addr !== 15'd100 || mem_bus.mem_wr !== 1'b1) begin
      miss++;
      $display("FAIL abort_pre: writes=%0d errs=%0d addr=%0d wr=%b, want 100 0 100 1",
               nwr, nerr, mem_bus.mem_addr, mem_bus.mem_wr);
    end
    reload = 1'b1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    vec++;
    if (mem_bus.mem_wr !== 1'b0 || mem_bus.mem_addr !== 15'd0 || msx_reset !== 1'b1) begin
      miss++;
      $display("FAIL abort_drop: wr=%b addr=%0d rst=%b, want 0 0 1",
               mem_bus.mem_wr, mem_bus.mem_addr, msx_reset);
    end
    reload = 1'b0;
    serve(1'b1, 0, 3000, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || nwr !== 1024 || nerr !== 0 || la !== 15'd1023) begin
      miss++;
      $display("FAIL abort_restart: timeout=%0b writes=%0d errs=%0d last=%h, want 0 1024 0 03ff",
               to, nwr, nerr, la);
    end
  endtask

  task automatic test_simultaneous();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd1;
    pulse_reload(1);
    serve(1'b1, 5, 200, nwr, nerr, la, lc, ec, to);
    @(negedge clk);
    reload = 1'b1;
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    vec++;
    if (mem_bus.mem_wr !== 1'b0 || mem_bus.mem_addr !== 15'd0 || busy !== 1'b1) begin
      miss++;
      $display("FAIL reload_vs_ack: wr=%b addr=%0d busy=%b, want 0 0 1",
               mem_bus.mem_wr, mem_bus.mem_addr, busy);
    end
    reload = 1'b0;
    mem_bus.mem_ack = 1'b0;
    serve(1'b1, 0, 3000, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || nwr !== 1024 || nerr !== 0) begin
      miss++;
      $display("FAIL simul_restart: timeout=%0b writes=%0d errs=%0d, want 0 1024 0", to, nwr, nerr);
    end
  endtask

  task automatic test_stray_ack();
    mem_bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || msx_reset !== 1'b0 || mem_bus.mem_wr !== 1'b0) begin
        miss++;
        $display("FAIL stray_ack[%0d]: busy=%b rst=%b wr=%b, want 0 0 0",
                 i, busy, msx_reset, mem_bus.mem_wr);
      end
    end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    int nwr, nerr, lc, ec; logic [14:0] la; bit to;
    sram_size = 8'd1;
    pulse_reload(1);
    serve(1'b1, 50, 500, nwr, nerr, la, lc, ec, to);
    @(negedge clk);
    vec++;
    if (mem_bus.mem_wr !== 1'b1 || mem_bus.mem_addr !== 15'd50) begin
      miss++;
      $display("FAIL async_pre: wr=%b addr=%0d, want 1 50", mem_bus.mem_wr, mem_bus.mem_addr);
    end
    #2;
    reset_n = 1'b0;
    mem_bus.mem_ack = 1'b0;
    #1;
    vec++;
    if (mem_bus.mem_wr !== 1'b0 || msx_reset !== 1'b1 || busy !== 1'b1 || mem_bus.mem_addr !== 15'd0) begin
      miss++;
      $display("FAIL async_reset: wr=%b rst=%b busy=%b addr=%0d, want 0 1 1 0",
               mem_bus.mem_wr, msx_reset, busy, mem_bus.mem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    serve(1'b1, 0, 3000, nwr, nerr, la, lc, ec, to);
    vec++;
    if (to !== 1'b0 || nwr !== 1024 || nerr !== 0 || la !== 15'd1023) begin
      miss++;
      $display("FAIL async_restart: timeout=%0b writes=%0d errs=%0d last=%h, want 0 1024 0 03ff",
               to, nwr, nerr, la);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_clear_1k();
    test_clamp();
    test_abort();
    test_simultaneous();
    test_stray_ack();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
